// File: rtl/fpmul_arb_pkg.sv
// Shared types and constants for the two-requester FPmul arbiter.
// Optional feature macro: FPMUL_ARB_PERF_EN (performance counters).
package fpmul_arb_pkg;

    localparam int NREQ  = 2;
    localparam int ID_W  = 1;
    localparam int CNT_W = 16;
    localparam int FP_W  = 32;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/fpmul_arbiter_if.sv
// Requester-side handshake and result bus of the FPmul arbiter.
interface fpmul_arbiter_if;
    import fpmul_arb_pkg::*;

    logic            vin0;
    logic            vin1;
    logic [FP_W-1:0] a0;
    logic [FP_W-1:0] b0;
    logic [FP_W-1:0] a1;
    logic [FP_W-1:0] b1;
    logic            ready0;
    logic            ready1;
    logic [FP_W-1:0] dout;
    logic            vout0;
    logic            vout1;

    modport master (
        output vin0, vin1, a0, b0, a1, b1,
        input  ready0, ready1, dout, vout0, vout1
    );

    modport slave (
        input  vin0, vin1, a0, b0, a1, b1,
        output ready0, ready1, dout, vout0, vout1
    );

endinterface

// File: rtl/fpmul_tag_pipe.sv
// Non-stalling shift register of {valid, id} tags that shadows the FPmul pipeline.
module fpmul_tag_pipe
    import fpmul_arb_pkg::*;
#(
    parameter int DEPTH = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    input  tag_t tag_in,
    output tag_t tag_out,
    output logic any_valid
);

    tag_t [DEPTH-1:0] stage_r;

    // Tag shift; flush drops every in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_r <= '0;
        end else if (flush) begin
            stage_r <= '0;
        end else begin
            stage_r[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    // OR of all stage valids.
    always_comb begin
        any_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            any_valid = any_valid | stage_r[i].valid;
        end
    end

    assign tag_out = stage_r[DEPTH-1];

endmodule

// File: rtl/fpmul_arbiter.sv
// Round-robin arbiter sharing one pipelined FPmul between two requesters.
// Optional feature macro: FPMUL_ARB_PERF_EN adds issue/conflict counters.
module fpmul_arbiter
    import fpmul_arb_pkg::*;
#(
    parameter int LAT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    fpmul_arbiter_if.slave   bus,
    output logic [FP_W-1:0]  fp_a,
    output logic [FP_W-1:0]  fp_b,
    input  logic [FP_W-1:0]  fp_z,
    output logic             busy
`ifdef FPMUL_ARB_PERF_EN
    ,
    output logic [CNT_W-1:0] issue_cnt0,
    output logic [CNT_W-1:0] issue_cnt1,
    output logic [CNT_W-1:0] conflict_cnt
`endif
);

    logic            ready0_s;
    logic            ready1_s;
    logic            accept_s;
    logic            prio_r;
    logic [FP_W-1:0] fp_a_r;
    logic [FP_W-1:0] fp_b_r;
    logic [FP_W-1:0] dout_r;
    logic            vout0_r;
    logic            vout1_r;
    logic            busy_r;
    logic            any_valid_s;
    tag_t            tag_in_s;
    tag_t            tag_out_s;

    // Grant: a lone requester wins, a tie goes to prio_r, flush blocks all.
    always_comb begin
        ready0_s = 1'b0;
        ready1_s = 1'b0;
        if (flush) begin
            ready0_s = 1'b0;
            ready1_s = 1'b0;
        end else if (bus.vin0 && bus.vin1) begin
            ready0_s = ~prio_r;
            ready1_s = prio_r;
        end else begin
            ready0_s = bus.vin0;
            ready1_s = bus.vin1;
        end
        accept_s       = (bus.vin0 & ready0_s) | (bus.vin1 & ready1_s);
        tag_in_s.valid = accept_s;
        tag_in_s.id    = ready1_s;
    end

    // Operand registers and priority; priority passes to the requester not served.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fp_a_r <= {FP_W{1'b0}};
            fp_b_r <= {FP_W{1'b0}};
            prio_r <= 1'b0;
        end else if (accept_s) begin
            fp_a_r <= ready1_s ? bus.a1 : bus.a0;
            fp_b_r <= ready1_s ? bus.b1 : bus.b0;
            prio_r <= ready0_s;
        end else begin
            fp_a_r <= fp_a_r;
            fp_b_r <= fp_b_r;
            prio_r <= prio_r;
        end
    end

    fpmul_tag_pipe #(
        .DEPTH (LAT + 1)
    ) u_tag_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .tag_in    (tag_in_s),
        .tag_out   (tag_out_s),
        .any_valid (any_valid_s)
    );

    // Result capture and routing; busy is held through the final result pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_r  <= {FP_W{1'b0}};
            vout0_r <= 1'b0;
            vout1_r <= 1'b0;
            busy_r  <= 1'b0;
        end else if (flush) begin
            vout0_r <= 1'b0;
            vout1_r <= 1'b0;
            busy_r  <= 1'b0;
        end else if (tag_out_s.valid) begin
            dout_r  <= fp_z;
            vout0_r <= (tag_out_s.id == 1'b0);
            vout1_r <= (tag_out_s.id == 1'b1);
            busy_r  <= any_valid_s;
        end else begin
            vout0_r <= 1'b0;
            vout1_r <= 1'b0;
            busy_r  <= any_valid_s;
        end
    end

`ifdef FPMUL_ARB_PERF_EN
    logic [CNT_W-1:0] issue_cnt0_r;
    logic [CNT_W-1:0] issue_cnt1_r;
    logic [CNT_W-1:0] conflict_cnt_r;

    // Wrapping event counters; flush deliberately leaves them alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt0_r   <= {CNT_W{1'b0}};
            issue_cnt1_r   <= {CNT_W{1'b0}};
            conflict_cnt_r <= {CNT_W{1'b0}};
        end else begin
            issue_cnt0_r   <= issue_cnt0_r + {{(CNT_W-1){1'b0}}, (accept_s & ready0_s)};
            issue_cnt1_r   <= issue_cnt1_r + {{(CNT_W-1){1'b0}}, (accept_s & ready1_s)};
            conflict_cnt_r <= conflict_cnt_r + {{(CNT_W-1){1'b0}}, (bus.vin0 & bus.vin1 & ~flush)};
        end
    end

    assign issue_cnt0   = issue_cnt0_r;
    assign issue_cnt1   = issue_cnt1_r;
    assign conflict_cnt = conflict_cnt_r;
`endif

    assign bus.ready0 = ready0_s;
    assign bus.ready1 = ready1_s;
    assign bus.dout   = dout_r;
    assign bus.vout0  = vout0_r;
    assign bus.vout1  = vout1_r;
    assign fp_a       = fp_a_r;
    assign fp_b       = fp_b_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_fpmul_arbiter.sv
// Self-checking bench for fpmul_arbiter with a behavioural FPmul and scoreboard.
// Honours FPMUL_ARB_PERF_EN when defined.
module tb_fpmul_arbiter;
    localparam int LAT = 4;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [31:0] fp_a;
    logic [31:0] fp_b;
    logic [31:0] fp_z;
    logic        busy;
`ifdef FPMUL_ARB_PERF_EN
    logic [15:0] issue_cnt0;
    logic [15:0] issue_cnt1;
    logic [15:0] conflict_cnt;
`endif

    fpmul_arbiter_if bus ();

    fpmul_arbiter #(.LAT(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus),
        .fp_a  (fp_a),
        .fp_b  (fp_b),
        .fp_z  (fp_z),
        .busy  (busy)
`ifdef FPMUL_ARB_PERF_EN
        ,
        .issue_cnt0   (issue_cnt0),
        .issue_cnt1   (issue_cnt1),
        .conflict_cnt (conflict_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-precision multiply (RNE, flush-to-zero, NaN treated as inf).
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        int          ea, eb, e;
        logic [47:0] p;
        logic [23:0] m;
        logic        g, st;
        logic [24:0] mr;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if (ea == 255 || eb == 255) return {s, 8'hFF, 23'h0};
        if (ea == 0 || eb == 0) return {s, 31'h0};
        p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = ea + eb - 127;
        if (p[47]) begin
            m = p[47:24]; g = p[23]; st = |p[22:0]; e = e + 1;
        end else begin
            m = p[46:23]; g = p[22]; st = |p[21:0];
        end
        mr = {1'b0, m} + ((g && (st || m[0])) ? 25'd1 : 25'd0);
        if (mr[24]) begin
            mr = mr >> 1;
            e  = e + 1;
        end
        if (e >= 255) return {s, 8'hFF, 23'h0};
        if (e <= 0) return {s, 31'h0};
        return {s, e[7:0], mr[22:0]};
    endfunction

    // External FPmul stand-in: result stable LAT edges after the operands change.
    logic [31:0] z_pipe [LAT];
    always @(posedge clk) begin
        z_pipe[0] <= fmul(fp_a, fp_b);
        for (int i = 1; i < LAT; i++) z_pipe[i] <= z_pipe[i-1];
    end
    assign fp_z = z_pipe[LAT-1];

    typedef struct {
        int          due;
        logic        id;
        logic [31:0] val;
    } exp_t;

    exp_t        q[$];
    int          checks, errors, cyc;
    int          seen0, seen1;
    logic        m_prio;
    logic [31:0] m_dout, m_fpa, m_fpb;
    logic        last_g0, last_g1;
    int          m_iss0, m_iss1, m_conf;

    task automatic model_reset();
        q.delete();
        m_prio = 1'b0; m_dout = 32'h0; m_fpa = 32'h0; m_fpb = 32'h0;
        m_iss0 = 0; m_iss1 = 0; m_conf = 0;
    endtask

    // One clock cycle: predict grant, advance, then compare every output.
    task automatic tick();
        logic        g0, g1, busy_e, v0_e, v1_e;
        logic [31:0] oa, ob, d_e;
        #1;
        g0 = 1'b0; g1 = 1'b0;
        if (!flush) begin
            if (bus.vin0 && bus.vin1) begin
                g0 = (m_prio == 1'b0); g1 = !g0;
            end else begin
                g0 = bus.vin0; g1 = bus.vin1;
            end
        end
        checks++;
        if (bus.ready0 !== g0 || bus.ready1 !== g1) begin
            errors++;
            $display("FAIL ready cyc=%0d got=%b%b exp=%b%b", cyc, bus.ready0, bus.ready1, g0, g1);
        end
        oa = g1 ? bus.a1 : bus.a0;
        ob = g1 ? bus.b1 : bus.b0;
        if (bus.vin0 && bus.vin1 && !flush) m_conf++;
        if (flush) q.delete();
        @(posedge clk);
        cyc++;
        if (g0 || g1) begin
            q.push_back('{cyc + LAT + 1, g1, fmul(oa, ob)});
            m_prio = g0;
            m_fpa = oa; m_fpb = ob;
            if (g0) m_iss0++; else m_iss1++;
        end
        last_g0 = g0; last_g1 = g1;
        #1;
        busy_e = 1'b0;
        foreach (q[i]) if (q[i].due >= cyc && q[i].due <= cyc + LAT) busy_e = 1'b1;
        v0_e = 1'b0; v1_e = 1'b0; d_e = m_dout;
        if (q.size() > 0 && q[0].due == cyc) begin
            v0_e = !q[0].id; v1_e = q[0].id; d_e = q[0].val; m_dout = q[0].val;
            void'(q.pop_front());
        end
        checks++;
        if (bus.vout0 !== v0_e || bus.vout1 !== v1_e || bus.dout !== d_e) begin
            errors++;
            $display("FAIL result cyc=%0d got=%b%b/%h exp=%b%b/%h", cyc, bus.vout0, bus.vout1, bus.dout, v0_e, v1_e, d_e);
        end
        checks++;
        if (busy !== busy_e) begin
            errors++;
            $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, busy_e);
        end
        checks++;
        if (fp_a !== m_fpa || fp_b !== m_fpb) begin
            errors++;
            $display("FAIL operands cyc=%0d got=%h/%h exp=%h/%h", cyc, fp_a, fp_b, m_fpa, m_fpb);
        end
`ifdef FPMUL_ARB_PERF_EN
        checks++;
        if (issue_cnt0 !== 16'(m_iss0) || issue_cnt1 !== 16'(m_iss1) || conflict_cnt !== 16'(m_conf)) begin
            errors++;
            $display("FAIL perf cyc=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", cyc, issue_cnt0, issue_cnt1,
                     conflict_cnt, m_iss0, m_iss1, m_conf);
        end
`endif
        if (bus.vout0 === 1'b1) seen0++;
        if (bus.vout1 === 1'b1) seen1++;
    endtask

    task automatic drain();
        flush = 1'b0; bus.vin0 = 1'b0; bus.vin1 = 1'b0;
        for (int i = 0; i < LAT + 4; i++) tick();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain left=%0d exp=0", q.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0;
        bus.vin0 = 1'b0; bus.vin1 = 1'b1;
        bus.a0 = 32'h0; bus.b0 = 32'h0; bus.a1 = 32'h0; bus.b1 = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.ready0 !== 1'b0 || bus.ready1 !== 1'b1) begin
            errors++; $display("FAIL reset_ready_vin1 got=%b%b exp=01", bus.ready0, bus.ready1);
        end
        bus.vin0 = 1'b1;
        #1;
        checks++;
        if (bus.ready0 !== 1'b1 || bus.ready1 !== 1'b0) begin
            errors++; $display("FAIL reset_ready_both got=%b%b exp=10", bus.ready0, bus.ready1);
        end
        checks++;
        if (bus.dout !== 32'h0 || bus.vout0 !== 1'b0 || bus.vout1 !== 1'b0 || busy !== 1'b0 ||
            fp_a !== 32'h0 || fp_b !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs got dout=%h v=%b%b busy=%b fp=%h/%h exp zeros",
                     bus.dout, bus.vout0, bus.vout1, busy, fp_a, fp_b);
        end
        bus.vin0 = 1'b0; bus.vin1 = 1'b0;
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic test_contention();
        int s0, s1;
        s0 = seen0; s1 = seen1;
        bus.vin0 = 1'b1; bus.vin1 = 1'b1;
        bus.a0 = $urandom; bus.b0 = $urandom; bus.a1 = $urandom; bus.b1 = $urandom;
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++;
            if (bus.ready0 !== ((i % 2) == 0)) begin
                errors++; $display("FAIL contention_alt i=%0d got ready0=%b exp=%b", i, bus.ready0, (i % 2) == 0);
            end
            tick();
            if (last_g0) begin bus.a0 = $urandom; bus.b0 = $urandom; end
            if (last_g1) begin bus.a1 = $urandom; bus.b1 = $urandom; end
        end
`ifdef FPMUL_ARB_PERF_EN
        checks++;
        if (conflict_cnt !== 16'd8) begin
            errors++; $display("FAIL contention_conflicts got=%0d exp=8", conflict_cnt);
        end
`endif
        drain();
        checks++;
        if (seen0 - s0 != 4 || seen1 - s1 != 4) begin
            errors++; $display("FAIL contention_pulses got=%0d/%0d exp=4/4", seen0 - s0, seen1 - s1);
        end
    endtask

    task automatic test_single();
        bus.vin0 = 1'b1; bus.a0 = 32'h40000000; bus.b0 = 32'h40400000;
        tick();
        bus.vin0 = 1'b0;
        for (int i = 1; i <= LAT + 1; i++) begin
            tick();
            checks++;
            if (i == LAT + 1) begin
                if (bus.vout0 !== 1'b1 || bus.vout1 !== 1'b0 || bus.dout !== 32'h40C00000) begin
                    errors++; $display("FAIL single_result got=%b%b/%h exp=10/40c00000", bus.vout0, bus.vout1, bus.dout);
                end
            end else if (bus.vout0 !== 1'b0 || bus.vout1 !== 1'b0) begin
                errors++; $display("FAIL single_early i=%0d got=%b%b exp=00", i, bus.vout0, bus.vout1);
            end
        end
        drain();
    endtask

    task automatic test_streaming();
        int s1;
        s1 = seen1;
        bus.vin1 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.a1 = $urandom; bus.b1 = $urandom;
            tick();
        end
        drain();
        checks++;
        if (seen1 - s1 != 20) begin
            errors++; $display("FAIL stream_pulses got=%0d exp=20", seen1 - s1);
        end
    endtask

    task automatic test_flush();
        int s0, s1;
        s0 = seen0; s1 = seen1;
        bus.vin0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.a0 = $urandom; bus.b0 = $urandom;
            tick();
        end
        bus.vin0 = 1'b0;
        tick();
        flush = 1'b1; bus.vin1 = 1'b1; bus.a1 = 32'h3FC00000; bus.b1 = 32'h40800000;
        tick();
        flush = 1'b0;
        tick();
        drain();
        checks++;
        if (seen0 - s0 != 0 || seen1 - s1 != 1) begin
            errors++; $display("FAIL flush_pulses got=%0d/%0d exp=0/1", seen0 - s0, seen1 - s1);
        end
        checks++;
        if (m_dout !== 32'h40C00000 || bus.dout !== 32'h40C00000) begin
            errors++; $display("FAIL flush_next_result got=%h exp=40c00000", bus.dout);
        end
    endtask

    task automatic test_special();
        bus.vin0 = 1'b1; bus.a0 = 32'h7F800000; bus.b0 = 32'h3F800000;
        tick();
        bus.vin0 = 1'b0;
        repeat (LAT + 1) tick();
        checks++;
        if (bus.vout0 !== 1'b1 || bus.dout !== 32'h7F800000) begin
            errors++; $display("FAIL special_inf got=%b/%h exp=1/7f800000", bus.vout0, bus.dout);
        end
        drain();
    endtask

    task automatic test_reset_midflight();
        int s0, s1;
        bus.vin0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.a0 = $urandom; bus.b0 = $urandom;
            tick();
        end
        bus.vin0 = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.dout !== 32'h0 || bus.vout0 !== 1'b0 || bus.vout1 !== 1'b0 || busy !== 1'b0 ||
            fp_a !== 32'h0 || fp_b !== 32'h0) begin
            errors++;
            $display("FAIL midreset_outputs got dout=%h v=%b%b busy=%b fp=%h/%h exp zeros",
                     bus.dout, bus.vout0, bus.vout1, busy, fp_a, fp_b);
        end
        @(posedge clk);
        cyc++;
        #1;
        model_reset();
        rst_n = 1'b1;
        s0 = seen0; s1 = seen1;
        drain();
        checks++;
        if (seen0 != s0 || seen1 != s1) begin
            errors++; $display("FAIL midreset_pulses got=%0d/%0d exp=0/0", seen0 - s0, seen1 - s1);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 120; i++) begin
            if (!bus.vin0) begin
                bus.vin0 = 1'($urandom_range(0, 1)); bus.a0 = $urandom; bus.b0 = $urandom;
            end
            if (!bus.vin1) begin
                bus.vin1 = 1'($urandom_range(0, 1)); bus.a1 = $urandom; bus.b1 = $urandom;
            end
            flush = ($urandom_range(0, 11) == 0);
            tick();
            if (last_g0) bus.vin0 = 1'b0;
            if (last_g1) bus.vin1 = 1'b0;
        end
        drain();
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0; seen0 = 0; seen1 = 0;
        last_g0 = 1'b0; last_g1 = 1'b0;
        model_reset();
        test_reset();
        test_contention();
        test_single();
        test_streaming();
        test_flush();
        test_special();
        test_reset_midflight();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
